encoder8x3_seq: RTL and testbench



---
 rtl/encoder8x3_seq.sv | 170 +++++++++++++++++
 tb/tb_encoder8x3_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/encoder8x3_seq.sv
// encoder8x3_seq: sequential 8-to-3 event encoder.
// Accepts a multi-hot 8-bit vector over a valid/ready handshake and streams
// out one 3-bit index per set bit, in priority order selected by LSB_FIRST.
// Optional feature macro: ENCODER_ZERO_FLAG_EN (adds the zero port and turns
// an all-zero vector into a single flagged beat instead of dropping it).
module encoder8x3_seq #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out,
`ifdef ENCODER_ZERO_FLAG_EN
    output logic       zero,
`endif
    output logic       out_last
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t     state_q,     state_d;
    logic [7:0] pending_q,   pending_d;
    logic [2:0] out_q,       out_d;
    logic       out_last_q,  out_last_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q,  in_ready_d;
    logic       zero_q,      zero_d;
    logic [7:0] remain_s;

    // Index of the highest-priority set bit; 0 when the vector is empty.
    function automatic logic [2:0] pick_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (LSB_FIRST != 0) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    idx = 3'(i);
                end else begin
                    idx = idx;
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    idx = 3'(i);
                end else begin
                    idx = idx;
                end
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic is_single(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

    // Next-state, pending-vector and registered-output computation.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        out_d       = out_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        zero_d      = zero_q;
        remain_s    = pending_q & ~(8'b0000_0001 << out_q);
        case (state_q)
            ST_IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    if (in != 8'h00) begin
                        pending_d   = in;
                        out_d       = pick_idx(in);
                        out_last_d  = is_single(in);
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        zero_d      = 1'b0;
                        state_d     = ST_EMIT;
                    end else begin
`ifdef ENCODER_ZERO_FLAG_EN
                        // Empty vector becomes one flagged final beat.
                        pending_d   = 8'h00;
                        out_d       = 3'd0;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        zero_d      = 1'b1;
                        state_d     = ST_EMIT;
`else
                        // Empty vector is consumed silently.
                        state_d     = ST_IDLE;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    pending_d = remain_s;
                    if (out_last_q) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        zero_d      = 1'b0;
                    end else begin
                        out_d      = pick_idx(remain_s);
                        out_last_d = is_single(remain_s);
                        zero_d     = 1'b0;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pending_d   = 8'h00;
                out_d       = 3'd0;
                out_last_d  = 1'b0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b0;
                zero_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= 8'h00;
            out_q       <= 3'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_last  = out_last_q;
`ifdef ENCODER_ZERO_FLAG_EN
    assign zero      = zero_q;
`else
    logic unused_zero_s;
    assign unused_zero_s = zero_q;
`endif

endmodule

// File: tb/tb_encoder8x3_seq.sv
// Directed self-checking bench for encoder8x3_seq.
// Two instances share all inputs: dut_l scans LSB first, dut_m scans MSB first.
module tb_encoder8x3_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;
    logic       in_ready_l, out_valid_l, out_last_l;
    logic [2:0] out_l;
    logic       in_ready_m, out_valid_m, out_last_m;
    logic [2:0] out_m;
`ifdef ENCODER_ZERO_FLAG_EN
    logic       zero_l, zero_m;
`endif

    int total = 0;
    int bad   = 0;

    encoder8x3_seq #(.LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .in(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
        .out(out_l),
`ifdef ENCODER_ZERO_FLAG_EN
        .zero(zero_l),
`endif
        .out_last(out_last_l)
    );

    encoder8x3_seq #(.LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .in(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
        .out(out_m),
`ifdef ENCODER_ZERO_FLAG_EN
        .zero(zero_m),
`endif
        .out_last(out_last_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (out_valid_l !== 1'b0) begin bad++; $display("FAIL reset_out_valid cyc=%0d got=%0b want=0", c, out_valid_l); end
            total++; if (in_ready_l !== 1'b0) begin bad++; $display("FAIL reset_in_ready cyc=%0d got=%0b want=0", c, in_ready_l); end
        end
        total++; if (out_l !== 3'd0 || out_last_l !== 1'b0) begin bad++; $display("FAIL reset_out got=%0d/%0b want=0/0", out_l, out_last_l); end
        rst = 1'b0; in_valid = 1'b0;
        step();
        total++; if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0) begin bad++; $display("FAIL reset_release rdy=%0b vld=%0b want=1/0", in_ready_l, out_valid_l); end
    endtask

    task automatic test_single();
        in_vec = 8'b0010_0000; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out_valid_l !== 1'b1 || in_ready_l !== 1'b0) begin bad++; $display("FAIL single_hs vld=%0b rdy=%0b want=1/0", out_valid_l, in_ready_l); end
        total++; if (out_l !== 3'd5 || out_last_l !== 1'b1) begin bad++; $display("FAIL single_beat got=%0d/%0b want=5/1", out_l, out_last_l); end
`ifdef ENCODER_ZERO_FLAG_EN
        total++; if (zero_l !== 1'b0) begin bad++; $display("FAIL single_zero got=%0b want=0", zero_l); end
`endif
        step();
        total++; if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin bad++; $display("FAIL single_done vld=%0b rdy=%0b want=0/1", out_valid_l, in_ready_l); end
    endtask

    task automatic test_multi();
        logic [2:0] exp_l [4];
        logic [2:0] exp_m [4];
        exp_l = '{3'd1, 3'd2, 3'd4, 3'd7};
        exp_m = '{3'd7, 3'd4, 3'd2, 3'd1};
        in_vec = 8'b1001_0110; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid_l !== 1'b1 || out_l !== exp_l[i] || out_last_l !== (i == 3)) begin
                bad++; $display("FAIL multi_lsb beat=%0d got=%0b/%0d/%0b want=1/%0d/%0b", i, out_valid_l, out_l, out_last_l, exp_l[i], (i == 3));
            end
            total++; if (out_valid_m !== 1'b1 || out_m !== exp_m[i] || out_last_m !== (i == 3)) begin
                bad++; $display("FAIL multi_msb beat=%0d got=%0b/%0d/%0b want=1/%0d/%0b", i, out_valid_m, out_m, out_last_m, exp_m[i], (i == 3));
            end
            step();
        end
        total++; if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1 || out_valid_m !== 1'b0) begin
            bad++; $display("FAIL multi_done vld=%0b rdy=%0b vldm=%0b want=0/1/0", out_valid_l, in_ready_l, out_valid_m);
        end
    endtask

    task automatic test_backpressure();
        int beat;
        int c;
        logic [2:0] hold_l;
        logic       hold_last;
        in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
        step();
        beat = 0; c = 0;
        while (beat < 8 && c < 60) begin
            hold_l    = out_l;
            hold_last = out_last_l;
            out_ready = (c % 3 == 0);
            in_valid  = c[0];
            in_vec    = 8'h0F;
            if (out_ready) begin
                total++; if (out_valid_l !== 1'b1 || out_l !== 3'(beat) || out_last_l !== (beat == 7)) begin
                    bad++; $display("FAIL bp_lsb beat=%0d got=%0b/%0d/%0b want=1/%0d/%0b", beat, out_valid_l, out_l, out_last_l, beat, (beat == 7));
                end
                total++; if (out_m !== 3'(7 - beat)) begin
                    bad++; $display("FAIL bp_msb beat=%0d got=%0d want=%0d", beat, out_m, 7 - beat);
                end
                beat++;
                step();
            end else begin
                step();
                total++; if (out_l !== hold_l || out_last_l !== hold_last || out_valid_l !== 1'b1) begin
                    bad++; $display("FAIL bp_hold cyc=%0d got=%0d/%0b want=%0d/%0b", c, out_l, out_last_l, hold_l, hold_last);
                end
            end
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (beat != 8) begin bad++; $display("FAIL bp_timeout beats=%0d want=8", beat); end
        total++; if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin bad++; $display("FAIL bp_done vld=%0b rdy=%0b want=0/1", out_valid_l, in_ready_l); end
    endtask

    task automatic test_reset_mid();
        in_vec = 8'b1110_0000; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out_valid_l !== 1'b1 || out_l !== 3'd5) begin bad++; $display("FAIL rmid_first got=%0b/%0d want=1/5", out_valid_l, out_l); end
        rst = 1'b1;
        step();
        total++; if (out_valid_l !== 1'b0 || in_ready_l !== 1'b0 || out_l !== 3'd0 || out_last_l !== 1'b0) begin
            bad++; $display("FAIL rmid_reset vld=%0b rdy=%0b out=%0d last=%0b want=0/0/0/0", out_valid_l, in_ready_l, out_l, out_last_l);
        end
        rst = 1'b0;
        step();
        total++; if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0) begin bad++; $display("FAIL rmid_release rdy=%0b vld=%0b want=1/0", in_ready_l, out_valid_l); end
        in_vec = 8'b0000_0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out_valid_l !== 1'b1 || out_l !== 3'd0 || out_last_l !== 1'b1) begin
            bad++; $display("FAIL rmid_next got=%0b/%0d/%0b want=1/0/1", out_valid_l, out_l, out_last_l);
        end
        step();
        total++; if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin bad++; $display("FAIL rmid_done vld=%0b rdy=%0b want=0/1", out_valid_l, in_ready_l); end
    endtask

    task automatic test_zero();
        in_vec = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef ENCODER_ZERO_FLAG_EN
        total++; if (out_valid_l !== 1'b1 || out_l !== 3'd0 || out_last_l !== 1'b1 || zero_l !== 1'b1) begin
            bad++; $display("FAIL zero_beat got=%0b/%0d/%0b/%0b want=1/0/1/1", out_valid_l, out_l, out_last_l, zero_l);
        end
        step();
        total++; if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1 || zero_l !== 1'b0) begin
            bad++; $display("FAIL zero_done vld=%0b rdy=%0b zero=%0b want=0/1/0", out_valid_l, in_ready_l, zero_l);
        end
`else
        total++; if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin bad++; $display("FAIL zero_drop vld=%0b rdy=%0b want=0/1", out_valid_l, in_ready_l); end
        step();
        total++; if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin bad++; $display("FAIL zero_idle vld=%0b rdy=%0b want=0/1", out_valid_l, in_ready_l); end
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_reset_mid();
        test_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
